// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the LSU UART receive (and transmit) paths.
//   rx_state_t   : receive FSM state encoding
//   DATA_BITS    : data bits per frame
//   STOP_BITS    : stop bits per frame
//   even_parity(): parity bit value that makes the total count of ones even
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Even parity: the parity bit equals the XOR of the data bits, so data
    // plus parity always carries an even number of ones.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO, shared by the UART rx/tx paths.
// Ports:
//   clk      in   system clock, posedge
//   rst      in   synchronous active-high reset; empties the FIFO
//   push     in   write request (accepted when not full, or full with a pop)
//   wr_data  in   WIDTH-bit write data
//   pop      in   read request (ignored when empty)
//   rd_data  out  head entry; all zeros when empty
//   push_ack out  high when the current push request is accepted
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  number of stored entries, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     push_ack,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // A pop frees the head slot during the same edge, so a full FIFO can
    // still take a push when it is simultaneously being read.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    // Pointer and occupancy bookkeeping. Pointers are AW bits wide and
    // wrap modulo DEPTH on their own because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are only visible through rd_data when the
    // FIFO is non-empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Status and the fall-through head value, forced to zero when empty.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_COUNT);
        count    = count_q;
        push_ack = do_push;
        rd_data  = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: rtl/uart_rx_lsu.sv
// ---------------------------------------------------------------------------
// uart_rx_lsu
// Receive half of the LSU UART: deserialises frames from the rx pin, buffers
// good bytes in a FIFO and hands them to the load/store unit with a Get/flag
// handshake.
// Ports:
//   clk        in   system clock, posedge
//   rst        in   synchronous active-high reset
//   rx_serial  in   asynchronous serial input, idle high
//   Get        in   pop request, honoured only while rd_flag=1
//   clr_err    in   one-cycle pulse clearing the sticky error flags
//   uart_in    out  FIFO head byte, 8'h00 when empty
//   rd_flag    out  FIFO not empty
//   Rxff       out  FIFO full
//   done_r     out  one-cycle pulse when a good byte enters the FIFO
//   frame_err  out  sticky: stop bit sampled low
//   overrun    out  sticky: good byte dropped because the FIFO was full
//   parity_err out  sticky: parity mismatch (tied low without parity)
// Configuration macro: UART_RX_PARITY_EN -> 8E1 frames with a PARITY state;
// otherwise 8N1 frames.
// ---------------------------------------------------------------------------
module uart_rx_lsu
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    input  logic       Get,
    input  logic       clr_err,
    output logic [7:0] uart_in,
    output logic       rd_flag,
    output logic       Rxff,
    output logic       done_r,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);

    rx_state_t state;
    rx_state_t next_state;

    logic                 rx_meta;
    logic                 rx_sync;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bad;
    logic                 push_req;

    logic                 half_tick;
    logic                 bit_tick;
    logic                 cnt_restart;
    logic                 data_sample;
    logic                 par_sample;
    logic                 stop_sample;

    logic                 fifo_push_ack;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Two-flop synchroniser on the raw pin. Both flops reset high so that a
    // reset never looks like the falling edge of a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. START re-checks the line half a bit in, which both
    // rejects glitches and centres every later sample in its bit. STOP leaves
    // at mid-stop-bit so a following start bit is never missed.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!rx_sync) next_state = START;
            end
            START: begin
                if (half_tick) next_state = rx_sync ? IDLE : DATA;
            end
            DATA: begin
                if (bit_tick && bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) next_state = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: which sample point, if any, falls in this cycle.
    always_comb begin
        half_tick   = (state == START) && (clk_cnt == HALF_LAST);
        bit_tick    = (clk_cnt == BIT_LAST);
        cnt_restart = (state == IDLE) || half_tick || bit_tick;
        data_sample = (state == DATA)   && bit_tick;
        par_sample  = (state == PARITY) && bit_tick;
        stop_sample = (state == STOP)   && bit_tick;
    end

    // Baud counter, bit counter and shift register. Bits arrive LSB first,
    // so each sample enters at the top and moves down. push_req is raised
    // by a good stop sample and feeds the FIFO during the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bad <= 1'b0;
            push_req   <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (cnt_restart) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (state == IDLE) begin
                bit_cnt    <= '0;
                parity_bad <= 1'b0;
            end
            if (data_sample) begin
                shift   <= {rx_sync, shift[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_sample) begin
                parity_bad <= (rx_sync != even_parity(shift));
            end
            if (stop_sample) begin
                push_req <= rx_sync & ~parity_bad;
            end
        end
    end

    // Sticky error flags. A new error event in the same cycle as clr_err
    // takes priority, so the flag stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (stop_sample & ~rx_sync) | (frame_err & ~clr_err);
            overrun   <= (push_req & ~fifo_push_ack) | (overrun & ~clr_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error flag, set at the parity sample when the bit disagrees
    // with the even parity of the received byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= (par_sample & (rx_sync != even_parity(shift)))
                        | (parity_err & ~clr_err);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Receive buffer. A pop is only requested while data is present, so a
    // Get against an empty FIFO never moves the pointers.
    assign fifo_pop = Get & ~fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .wr_data  (shift),
        .pop      (fifo_pop),
        .rd_data  (uart_in),
        .push_ack (fifo_push_ack),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // LSU-facing status. done_r only pulses when the byte was really stored.
    always_comb begin
        rd_flag = (fifo_count != '0);
        Rxff    = fifo_full;
        done_r  = fifo_push_ack;
    end

endmodule

// File: tb/tb_uart_rx_lsu.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_lsu
// Self-checking bench for uart_rx_lsu (CLKS_PER_BIT=16, FIFO_DEPTH=8).
// Expected bytes are queued as frames are driven and compared as the bench
// pops them from the DUT. Honours UART_RX_PARITY_EN like the RTL.
// ---------------------------------------------------------------------------
module tb_uart_rx_lsu;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_serial;
    logic       Get;
    logic       clr_err;
    logic [7:0] uart_in;
    logic       rd_flag;
    logic       Rxff;
    logic       done_r;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int         vectors = 0;
    int         miscompares = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q [$];
    logic       exp_overrun = 1'b0;

    uart_rx_lsu #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .Get        (Get),
        .clr_err    (clr_err),
        .uart_in    (uart_in),
        .rd_flag    (rd_flag),
        .Rxff       (Rxff),
        .done_r     (done_r),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // 100 MHz-style clock.
    always #5 clk = ~clk;

    // Count done_r pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (done_r === 1'b1) done_cnt++;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        rx_serial = b;
        tick(CPB);
    endtask

    // Drive one whole frame; the parity bit is only sent in parity builds.
    task automatic applyStimulus(input logic [7:0] d, input logic stop_b,
                                 input logic par_b);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
`ifdef UART_RX_PARITY_EN
        sendBit(par_b);
`else
        if (par_b === 1'bx) $display("[TB] note: unknown parity argument");
`endif
        sendBit(stop_b);
        rx_serial = 1'b1;
    endtask

    // Good frame plus scoreboard model of the FIFO occupancy.
    task automatic sendGood(input logic [7:0] d);
        applyStimulus(d, 1'b1, ^d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_overrun = 1'b1;
    endtask

    task automatic popAndCheck(input string tag);
        checkOutput({tag, "_rdflag"}, rd_flag, 1);
        if (exp_q.size() > 0) checkOutput({tag, "_data"}, uart_in, exp_q.pop_front());
        else checkOutput({tag, "_underflow"}, exp_q.size(), 1);
        Get = 1'b1;
        tick(1);
        Get = 1'b0;
    endtask

    task automatic pulseClr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; rx_serial = 1'b1; Get = 1'b0; clr_err = 1'b0;
        tick(3);
        checkOutput("rst_uart_in", uart_in, 0);
        checkOutput("rst_rd_flag", rd_flag, 0);
        checkOutput("rst_Rxff", Rxff, 0);
        checkOutput("rst_flags", {done_r, frame_err, overrun, parity_err}, 0);
        rst = 1'b0;
        tick(5);

        // 1: single frame 0xA5, precise push latency
        $display("[TB] test 1: frame 0xA5");
        done_cnt = 0;
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(8'hA5 >> i);
`ifdef UART_RX_PARITY_EN
        sendBit(1'b0);
`endif
        rx_serial = 1'b1;
        exp_q.push_back(8'hA5);
        found = 1'b0;
        for (int i = 0; i < CPB && !found; i++) begin
            @(negedge clk);
            if (done_r === 1'b1) found = 1'b1;
        end
        checkOutput("t1_done_seen", found, 1);
        if (found) begin
            checkOutput("t1_rdflag_at_push", rd_flag, 0);
            @(posedge clk); #1;
            checkOutput("t1_rdflag_after", rd_flag, 1);
        end
        tick(CPB);
        checkOutput("t1_done_cnt", done_cnt, 1);
        popAndCheck("t1_pop");
        checkOutput("t1_rdflag_empty", rd_flag, 0);
        checkOutput("t1_uart_in_empty", uart_in, 0);

        // 2: short glitch on the line is rejected
        $display("[TB] test 2: glitch");
        done_cnt = 0;
        rx_serial = 1'b0; tick(4);
        rx_serial = 1'b1; tick(3 * CPB);
        checkOutput("t2_done_cnt", done_cnt, 0);
        checkOutput("t2_rd_flag", rd_flag, 0);
        checkOutput("t2_frame_err", frame_err, 0);

        // 3: bad stop bit
        $display("[TB] test 3: frame error");
        applyStimulus(8'h3C, 1'b0, ^8'h3C);
        tick(2 * CPB);
        checkOutput("t3_frame_err", frame_err, 1);
        checkOutput("t3_rd_flag", rd_flag, 0);
        checkOutput("t3_done_cnt", done_cnt, 0);
        pulseClr();
        checkOutput("t3_frame_err_clr", frame_err, 0);

        // 4: fill and overrun
        $display("[TB] test 4: fill and overrun");
        done_cnt = 0;
        for (int k = 1; k <= 8; k++) sendGood(8'(k));
        tick(2);
        checkOutput("t4_Rxff", Rxff, 1);
        checkOutput("t4_overrun_early", overrun, 0);
        sendGood(8'h09);
        tick(2);
        checkOutput("t4_overrun", overrun, exp_overrun);
        checkOutput("t4_done_cnt", done_cnt, 8);
        for (int k = 0; k < 8; k++) popAndCheck("t4_pop");
        checkOutput("t4_rd_flag_end", rd_flag, 0);
        checkOutput("t4_Rxff_end", Rxff, 0);
        pulseClr();
        checkOutput("t4_overrun_clr", overrun, 0);
        exp_overrun = 1'b0;

        // 5: reset in the middle of data bit 4
        $display("[TB] test 5: reset mid-frame");
        sendGood(8'h11);
        tick(2);
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b0);
        rx_serial = 1'b1;
        tick(CPB / 2);
        rst = 1'b1; tick(1); rst = 1'b0;
        exp_q.delete();
        done_cnt = 0;
        checkOutput("t5_uart_in", uart_in, 0);
        checkOutput("t5_rd_flag", rd_flag, 0);
        checkOutput("t5_others", {Rxff, done_r, frame_err, overrun, parity_err}, 0);
        tick(6 * CPB);
        sendGood(8'h5A);
        tick(2);
        checkOutput("t5_done_cnt", done_cnt, 1);
        popAndCheck("t5_pop");
        checkOutput("t5_rd_flag_end", rd_flag, 0);

`ifdef UART_RX_PARITY_EN
        // 6: parity mismatch then a good parity frame
        $display("[TB] test 6: parity");
        applyStimulus(8'h07, 1'b1, 1'b0);
        tick(2);
        checkOutput("t6_parity_err", parity_err, 1);
        checkOutput("t6_rd_flag", rd_flag, 0);
        checkOutput("t6_frame_err", frame_err, 0);
        sendGood(8'h07);
        tick(2);
        popAndCheck("t6_pop");
        pulseClr();
        checkOutput("t6_parity_clr", parity_err, 0);
`else
        checkOutput("t6_parity_tied", parity_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
